// File: rtl/argmax_unit.sv
// argmax_unit: scans NUM_CLASS signed scores from a registered-read score
// buffer and reports the index and value of the largest one.
//
// Handshake: start_i is a level sampled only in IDLE; score_data_i is taken
// one cycle after each cycle with score_en_o=1; valid_o is a single-cycle
// pulse with class_o/max_o already holding the new result.
//
// Pipeline: address issue -> memory return (rd_vld_q) -> compare register
// (cmp_vld_q). Registering the returned score before the comparator keeps the
// memory clock-to-out off the compare path. DRAIN therefore holds until the
// last index has left the compare register.
module argmax_unit #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [3:0]               score_addr_o,
    output logic                     score_en_o,
    input  logic signed [DATA_W-1:0] score_data_i,
    output logic [3:0]               class_o,
    output logic signed [DATA_W-1:0] max_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic [13:0]              img_cnt_o,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

    state_t                     state_q, state_d;
    logic [3:0]                 addr_q;
    logic                       rd_vld_q;
    logic [3:0]                 rd_idx_q;
    logic                       cmp_vld_q;
    logic [3:0]                 cmp_idx_q;
    logic signed [DATA_W-1:0]   cmp_data_q;
    logic signed [DATA_W-1:0]   run_max_q, run_max_d;
    logic [3:0]                 run_idx_q, run_idx_d;
    logic [3:0]                 class_q;
    logic signed [DATA_W-1:0]   max_q;
    logic [13:0]                img_cnt_q;
    logic                       last_cmp;
    logic                       enter_done;

    assign last_cmp   = cmp_vld_q && (cmp_idx_q == LAST_IDX);
    assign enter_done = (state_q == S_DRAIN) && last_cmp;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        score_en_o   = 1'b0;
        score_addr_o = addr_q;
        valid_o      = 1'b0;
        busy_o       = (state_q != S_IDLE);
        state_o      = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_READ;
            S_READ: begin
                score_en_o = 1'b1;
                if (addr_q == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: if (last_cmp) state_d = S_DONE;
            S_DONE: begin
                valid_o = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read address counter: steps once per READ cycle, parked at 0 otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                       addr_q <= '0;
        else if (state_q == S_READ && addr_q != LAST_IDX) addr_q <= addr_q + 4'd1;
        else                                             addr_q <= '0;
    end

    // Delayed-enable flags and compare register following the memory latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            cmp_data_q <= '0;
        end else begin
            rd_vld_q   <= score_en_o;
            rd_idx_q   <= addr_q;
            cmp_vld_q  <= rd_vld_q;
            cmp_idx_q  <= rd_idx_q;
            cmp_data_q <= score_data_i;
        end
    end

    // Running max: index 0 loads unconditionally, later scores only if strictly greater.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (cmp_vld_q && ((cmp_idx_q == 4'd0) || (cmp_data_q > run_max_q))) begin
            run_max_d = cmp_data_q;
            run_idx_d = cmp_idx_q;
        end
    end

    // Running max/index registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_max_q <= '0;
            run_idx_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
        end
    end

    // Published result and image counter change only on entry to DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            class_q   <= '0;
            max_q     <= '0;
            img_cnt_q <= '0;
        end else if (enter_done) begin
            class_q   <= run_idx_d;
            max_q     <= run_max_d;
            img_cnt_q <= img_cnt_q + 14'd1;
        end
    end

    assign class_o   = class_q;
    assign max_o     = max_q;
    assign img_cnt_o = img_cnt_q;

endmodule
